// File: rtl/garage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : garage_pkg
// Description : Shared state encoding and default constants for the garage
//               exit gate controller.
// Revision    : 1.0 - initial release
// ============================================================================
package garage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_CODE = 3'd1,
    ST_WRONG     = 3'd2,
    ST_OPEN      = 3'd3,
    ST_CLOSE     = 3'd4,
    ST_LOCKED    = 3'd5
  } gate_state_e;

  localparam logic [3:0]  c_default_exit_code = 4'hA;
  localparam int unsigned c_default_capacity  = 8;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider; one-clk tick every DIV cycles, the
//               first on the DIV-th cycle after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == c_last) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/exit_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exit_gate_ctrl
// Description : Garage exit gate: keypad code check, gate timing and
//               occupancy tracking. Define EXIT_LOCKOUT_EN to add the
//               wrong-code lockout state and the lockout output.
// Revision    : 1.0 - initial release
// ============================================================================
module exit_gate_ctrl
  import garage_pkg::*;
#(
  parameter int unsigned DIV           = 4,
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter int unsigned OPEN_TICKS    = 4,
  parameter logic [3:0]  EXIT_CODE     = c_default_exit_code,
  parameter int unsigned CAPACITY      = c_default_capacity
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_exit,
  input  logic       sensor_clear,
  input  logic [3:0] code,
  input  logic       code_valid,
  input  logic       car_entered,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic [3:0] occupancy,
  output logic [2:0] state_o
`ifdef EXIT_LOCKOUT_EN
  ,
  output logic       lockout
`endif
);

  localparam int unsigned TCNT_MAX = (2 * TIMEOUT_TICKS > OPEN_TICKS) ? 2 * TIMEOUT_TICKS : OPEN_TICKS;
  localparam int unsigned TCNT_W   = $clog2(TCNT_MAX + 1);

  gate_state_e       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        occupancy_q, occupancy_d;

  logic w_tick, w_code_ok, w_code_bad, w_timeout_hit, w_open_hit, w_dec;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // Limits fire on the tick that completes the Nth counted tick.
  assign w_code_ok     = code_valid && (code == EXIT_CODE);
  assign w_code_bad    = code_valid && (code != EXIT_CODE);
  assign w_timeout_hit = w_tick && (tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1));
  assign w_open_hit    = w_tick && (tcnt_q == TCNT_W'(OPEN_TICKS - 1));
  assign w_dec         = (state_q == ST_OPEN) && sensor_clear;

`ifdef EXIT_LOCKOUT_EN
  logic [1:0] wrong_cnt_q, wrong_cnt_d;
  logic       w_lock_hit;

  assign w_lock_hit = w_tick && (tcnt_q == TCNT_W'(2 * TIMEOUT_TICKS - 1));

  always_comb begin
    wrong_cnt_d = wrong_cnt_q;
    if (state_q == ST_WAIT_CODE || state_q == ST_WRONG) begin
      if (w_code_ok)                  wrong_cnt_d = 2'd0;
      else if (w_code_bad)            wrong_cnt_d = (wrong_cnt_q == 2'd2) ? 2'd0 : wrong_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wrong_cnt_q <= 2'd0;
    else       wrong_cnt_q <= wrong_cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sensor_exit && (occupancy_q != 4'd0)) state_d = ST_WAIT_CODE;
      end
      ST_WAIT_CODE, ST_WRONG: begin
        if (w_code_ok) begin
          state_d = ST_OPEN;
        end else if (w_code_bad) begin
`ifdef EXIT_LOCKOUT_EN
          state_d = (wrong_cnt_q == 2'd2) ? ST_LOCKED : ST_WRONG;
`else
          state_d = ST_WRONG;
`endif
        end else if (!sensor_exit || w_timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (sensor_clear)    state_d = ST_CLOSE;
        else if (w_open_hit) state_d = ST_IDLE;
      end
      ST_CLOSE: begin
        if (w_tick) state_d = ST_IDLE;
      end
`ifdef EXIT_LOCKOUT_EN
      ST_LOCKED: begin
        if (w_lock_hit) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_d != state_q) tcnt_d = '0;
    else if (w_tick)        tcnt_d = tcnt_q + TCNT_W'(1);
  end

  // An entry and an exit in the same cycle cancel out.
  always_comb begin
    occupancy_d = occupancy_q;
    if (car_entered && !w_dec) begin
      if (occupancy_q < 4'(CAPACITY)) occupancy_d = occupancy_q + 4'd1;
    end else if (w_dec && !car_entered) begin
      if (occupancy_q != 4'd0) occupancy_d = occupancy_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      occupancy_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign gate_open = (state_q == ST_OPEN);
  assign green_led = (state_q == ST_OPEN) || (state_q == ST_CLOSE);
`ifdef EXIT_LOCKOUT_EN
  assign red_led   = (state_q == ST_WRONG) || (state_q == ST_LOCKED);
  assign lockout   = (state_q == ST_LOCKED);
`else
  assign red_led   = (state_q == ST_WRONG);
`endif
  assign occupancy = occupancy_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_exit_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exit_gate_ctrl
// Description : Directed self-checking bench for exit_gate_ctrl (default
//               build, EXIT_LOCKOUT_EN undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exit_gate_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRONG = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_CLOSE = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_exit = 1'b0;
  logic       sensor_clear = 1'b0;
  logic [3:0] code = 4'h0;
  logic       code_valid = 1'b0;
  logic       car_entered = 1'b0;
  logic       gate_open, green_led, red_led;
  logic [3:0] occupancy;
  logic [2:0] state_o;
`ifdef EXIT_LOCKOUT_EN
  logic       lockout;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exit_gate_ctrl #(
    .DIV          (4),
    .TIMEOUT_TICKS(8),
    .OPEN_TICKS   (4),
    .EXIT_CODE    (4'hA),
    .CAPACITY     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_exit (sensor_exit),
    .sensor_clear(sensor_clear),
    .code        (code),
    .code_valid  (code_valid),
    .car_entered (car_entered),
    .gate_open   (gate_open),
    .green_led   (green_led),
    .red_led     (red_led),
    .occupancy   (occupancy),
    .state_o     (state_o)
`ifdef EXIT_LOCKOUT_EN
    ,
    .lockout     (lockout)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge numbers Ek count rising edges after the last reset edge E0;
  // the divider ticks are sampled on E4, E8, E12, ...
  initial begin
    step();
    step();
    chk("rst_state", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("rst_gate", {7'd0, gate_open}, 8'd0);
    chk("rst_green", {7'd0, green_led}, 8'd0);
    chk("rst_red", {7'd0, red_led}, 8'd0);
    chk("rst_occ", {4'd0, occupancy}, 8'd0);
    reset = 1'b0;

    // Normal exit: three entries, correct code, car clears
    car_entered = 1'b1;
    step(); step(); step();                       // E1..E3
    car_entered = 1'b0;
    chk("occ_after_3", {4'd0, occupancy}, 8'd3);
    sensor_exit = 1'b1;
    step();                                       // E4
    chk("to_wait", {5'd0, state_o}, {5'd0, S_WAIT});
    code = 4'hA; code_valid = 1'b1;
    step();                                       // E5
    code_valid = 1'b0;
    chk("open_state", {5'd0, state_o}, {5'd0, S_OPEN});
    chk("open_gate", {7'd0, gate_open}, 8'd1);
    chk("open_green", {7'd0, green_led}, 8'd1);
    chk("open_red", {7'd0, red_led}, 8'd0);
    sensor_clear = 1'b1;
    step();                                       // E6
    sensor_clear = 1'b0; sensor_exit = 1'b0;
    chk("close_state", {5'd0, state_o}, {5'd0, S_CLOSE});
    chk("close_occ", {4'd0, occupancy}, 8'd2);
    chk("close_gate", {7'd0, gate_open}, 8'd0);
    chk("close_green", {7'd0, green_led}, 8'd1);
    step();                                       // E7
    chk("close_hold", {5'd0, state_o}, {5'd0, S_CLOSE});
    step();                                       // E8 tick
    chk("close_to_idle", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("idle_green", {7'd0, green_led}, 8'd0);

    // Wrong code, then correct code; then open times out without clear
    sensor_exit = 1'b1;
    step();                                       // E9
    chk("wait2", {5'd0, state_o}, {5'd0, S_WAIT});
    code = 4'h3; code_valid = 1'b1;
    step();                                       // E10
    chk("wrong_state", {5'd0, state_o}, {5'd0, S_WRONG});
    chk("wrong_red", {7'd0, red_led}, 8'd1);
    chk("wrong_gate", {7'd0, gate_open}, 8'd0);
    chk("wrong_green", {7'd0, green_led}, 8'd0);
    code = 4'hA;
    step();                                       // E11
    code_valid = 1'b0; sensor_exit = 1'b0;
    chk("retry_gate", {7'd0, gate_open}, 8'd1);
    chk("retry_red", {7'd0, red_led}, 8'd0);
    for (int i = 0; i < 12; i++) step();          // E12..E23
    chk("open_hold", {5'd0, state_o}, {5'd0, S_OPEN});
    step();                                       // E24: 4th tick in OPEN
    chk("open_timeout", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("open_timeout_occ", {4'd0, occupancy}, 8'd2);

    // Code-entry timeout with sensor_exit held
    sensor_exit = 1'b1;
    step();                                       // E25
    chk("wait3", {5'd0, state_o}, {5'd0, S_WAIT});
    for (int i = 0; i < 30; i++) begin            // E26..E55
      step();
      chk("wait_hold", {5'd0, state_o}, {5'd0, S_WAIT});
      chk("wait_no_gate", {7'd0, gate_open}, 8'd0);
    end
    step();                                       // E56: 8th tick
    chk("wait_timeout", {5'd0, state_o}, {5'd0, S_IDLE});
    sensor_exit = 1'b0;

    // Car backs away
    sensor_exit = 1'b1;
    step();                                       // E57
    chk("wait4", {5'd0, state_o}, {5'd0, S_WAIT});
    sensor_exit = 1'b0;
    step();                                       // E58
    chk("exit_drop", {5'd0, state_o}, {5'd0, S_IDLE});

    // Reset while the gate is open
    sensor_exit = 1'b1;
    step();                                       // E59
    code = 4'hA; code_valid = 1'b1;
    step();                                       // E60
    code_valid = 1'b0;
    chk("pre_rst_gate", {7'd0, gate_open}, 8'd1);
    reset = 1'b1;
    step();                                       // new E0
    reset = 1'b0;
    chk("rst_open_gate", {7'd0, gate_open}, 8'd0);
    chk("rst_open_green", {7'd0, green_led}, 8'd0);
    chk("rst_open_occ", {4'd0, occupancy}, 8'd0);
    chk("rst_open_state", {5'd0, state_o}, {5'd0, S_IDLE});

    // Empty garage ignores sensor_exit
    step();                                       // E1
    chk("empty_stay_idle", {5'd0, state_o}, {5'd0, S_IDLE});
    sensor_exit = 1'b0;

    // Saturation at capacity
    car_entered = 1'b1;
    for (int i = 0; i < 8; i++) step();           // E2..E9
    chk("occ_full", {4'd0, occupancy}, 8'd8);
    step();                                       // E10
    car_entered = 1'b0;
    chk("occ_saturate", {4'd0, occupancy}, 8'd8);

    // Entry and exit in the same cycle
    sensor_exit = 1'b1;
    step();                                       // E11
    code = 4'hA; code_valid = 1'b1;
    step();                                       // E12
    code_valid = 1'b0;
    chk("open5", {5'd0, state_o}, {5'd0, S_OPEN});
    sensor_clear = 1'b1; car_entered = 1'b1;
    step();                                       // E13
    sensor_clear = 1'b0; car_entered = 1'b0; sensor_exit = 1'b0;
    chk("simul_state", {5'd0, state_o}, {5'd0, S_CLOSE});
    chk("simul_occ", {4'd0, occupancy}, 8'd8);
    step(); step();                               // E14, E15
    chk("close5_hold", {5'd0, state_o}, {5'd0, S_CLOSE});
    step();                                       // E16 tick
    chk("close5_idle", {5'd0, state_o}, {5'd0, S_IDLE});

    // Valid code beats timeout on the same edge
    sensor_exit = 1'b1;
    step();                                       // E17
    chk("wait6", {5'd0, state_o}, {5'd0, S_WAIT});
    for (int i = 0; i < 30; i++) step();          // E18..E47
    chk("wait6_hold", {5'd0, state_o}, {5'd0, S_WAIT});
    code = 4'hA; code_valid = 1'b1;
    step();                                       // E48: timeout tick
    code_valid = 1'b0; sensor_exit = 1'b0;
    chk("code_beats_timeout", {5'd0, state_o}, {5'd0, S_OPEN});
    chk("code_beats_timeout_gate", {7'd0, gate_open}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exit_gate_ctrl.md
EXIT_GATE_CTRL -- requirements
Module: exit_gate_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4: clk cycles per slow tick.
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 8: ticks allowed for code entry.
REQ-003 The block SHALL have parameter OPEN_TICKS, default 4: ticks the gate may stay open awaiting car clearance.
REQ-004 The block SHALL have parameter EXIT_CODE, default 4'hA: accepted exit code.
REQ-005 The block SHALL have parameter CAPACITY, default 8: maximum occupancy.
REQ-006 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port sensor_exit  input  1  car present at exit gate (level).
REQ-009 The block SHALL have port sensor_clear  input  1  car has passed the gate (level).
REQ-010 The block SHALL have port code  input  4  exit code from keypad.
REQ-011 The block SHALL have port code_valid  input  1  one-cycle strobe qualifying code.
REQ-012 The block SHALL have port car_entered  input  1  one-cycle pulse from the entry side.
REQ-013 The block SHALL have port gate_open  output  1  gate actuator.
REQ-014 The block SHALL have port green_led  output  1  code accepted.
REQ-015 The block SHALL have port red_led  output  1  wrong code.
REQ-016 The block SHALL have port occupancy  output  4  cars inside.
REQ-017 The block SHALL have port state_o  output  3  current FSM state encoding.

Function
REQ-018 Tick: one-clk pulse every DIV clk cycles, free-running from reset; first tick on the DIV-th cycle after reset release.
REQ-019 FSM states: IDLE, WAIT_CODE, WRONG, OPEN, CLOSE; outputs Moore-decoded from the state register.
REQ-020 IDLE -> WAIT_CODE when sensor_exit=1 and occupancy!=0; sensor_exit with occupancy=0 stays IDLE.
REQ-021 WAIT_CODE/WRONG: code_valid with code==EXIT_CODE -> OPEN; code_valid with wrong code -> WRONG.
REQ-022 WAIT_CODE/WRONG -> IDLE when sensor_exit=0 or tick count reaches TIMEOUT_TICKS; the valid-code transition has priority over timeout in the same cycle.
REQ-023 OPEN -> CLOSE on sensor_clear=1, decrementing occupancy in that same cycle; OPEN -> IDLE without decrement after OPEN_TICKS ticks.
REQ-024 CLOSE -> IDLE on the next tick.
REQ-025 The tick counter SHALL clear on every state transition.
REQ-026 Output decode: gate_open=1 in OPEN only; green_led=1 in OPEN and CLOSE; red_led=1 in WRONG only.
REQ-027 car_entered increments occupancy, saturating at CAPACITY.
REQ-028 Simultaneous car_entered and exit decrement SHALL leave occupancy unchanged.
REQ-029 Decrement at occupancy 0 SHALL saturate at 0.

Reset
REQ-030 reset=1 at a clk edge SHALL force IDLE, occupancy=0, tick divider=0, tick count=0, and gate_open/green_led/red_led=0, regardless of current state, including mid-OPEN.

Configuration
REQ-031 With EXIT_LOCKOUT_EN defined: add output lockout (1 bit); the third consecutive wrong code SHALL enter LOCKED (red_led=1, lockout=1, code ignored) for 2*TIMEOUT_TICKS ticks, then IDLE; a correct code clears the wrong count.
REQ-032 Without EXIT_LOCKOUT_EN: no lockout port and no LOCKED state; wrong codes are unlimited.

Structure
REQ-033 Shared package garage_pkg SHALL hold the state enum (including LOCKED encoding) and the default code and capacity constants.
REQ-034 The tick divider SHALL be a sub-module tick_gen (clk, reset, tick), parameterised by DIV.

Verification (DIV=4, TIMEOUT_TICKS=8, OPEN_TICKS=4, EXIT_CODE=4'hA, CAPACITY=8)
REQ-035 Scenario: 3 car_entered pulses, then sensor_exit, code 4'hA, then sensor_clear -> gate_open=1 one cycle after the strobe; occupancy 3->2 at the clear; IDLE 1 tick later.
REQ-036 Scenario: code 4'h3, then 4'hA -> red_led=1 in WRONG, then gate_open=1 with red_led=0.
REQ-037 Scenario: sensor_exit held with no code -> IDLE after 8 ticks (32 clk); gate never opens.
REQ-038 Scenario: 9 car_entered pulses -> occupancy=8; at occupancy 0, sensor_exit -> stays IDLE.
REQ-039 Scenario: reset asserted in OPEN -> next edge gate_open=0, occupancy=0, state_o=IDLE.
REQ-040 Scenario (EXIT_LOCKOUT_EN): 3 wrong codes -> lockout=1 for 16 ticks; a 4'hA during lockout is ignored.
